aes_col_round_ctrl: RTL
=======================

// Module: aes_col_round_ctrl
// PURPOSE
//  Sequencer for the column-serial AES-128 encryption datapath: one 32-bit state column per clk.
//  Accepts a start request, drives the 32-bit column datapath through the initial AddRoundKey and NR rounds,
//  then pulses done. Issues column select, round number, key-expansion step and last-round strobes.
//  The monitor/trigger logic samples the 32-bit state bus that this block sequences.
// PARAMETERS
//  NR      10  number of rounds, legal 1..15 (4-bit round counter)
//  NCOL    4   columns per state; fixed at 4, col is 2 bits
// PORTS
//  clk       in   1  clock; all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  start     in   1  request; accepted only when ready=1
//  ready     out  1  1 only in IDLE
//  busy      out  1  1 in LOAD, ROUND and DONE
//  ld_en     out  1  load column col (plaintext ^ key0) into state reg
//  rnd_en    out  1  apply round transform to column col
//  key_en    out  1  advance key schedule one round word-set; high when rnd_en & col==0
//  last_rnd  out  1  round==NR; datapath bypasses MixColumns
//  col       out  2  current column index 0..3
//  round     out  4  current round: 0 in LOAD, 1..NR in ROUND, 0 otherwise
//  done      out  1  one-cycle pulse; state bus holds ciphertext
// BEHAVIOUR
//  All outputs registered; the FSM state register is one-hot or binary, implementer's choice.
//  Reset: state=IDLE, ready=1, all other outputs 0, col=0, round=0.
//  IDLE:  start=1 at an edge -> LOAD; ready drops in the following cycle.
//  LOAD:  4 cycles, ld_en=1, col 0,1,2,3, round=0 -> ROUND with round=1, col=0.
//  ROUND: rnd_en=1; col increments each cycle. col wrap 3->0 increments round.
//         At round==NR and col==3 -> DONE. Total 4*NR cycles.
//  DONE:  exactly 1 cycle: done=1, busy=1, rnd_en=0, round=0, col=0 -> IDLE.
//  Timing: edge sampling start = edge 0; cycle k = interval after edge k-1.
//         With NR=10: ld_en in cycles 1-4, rnd_en in cycles 5-44, done in cycle 45, ready in cycle 46.
//  start is ignored while ready=0, including the DONE cycle. Requests are not queued.
//  Back-to-back: start held high -> new LOAD begins the cycle after ready returns (cycle 47 for NR=10).
//  rst mid-operation: IDLE at the next edge. No done pulse. Outputs take their reset values.
//  rst and start both high at the same edge: rst wins.
//  ld_en, rnd_en and done are mutually exclusive in every cycle.
// CONFIGURATION
//  AES_CTRL_STALL_EN defined:
//   - Adds input stall (1 bit).
//   - While stall=1 in LOAD or ROUND, state, col and round hold, and ld_en, rnd_en and key_en are forced 0.
//   - Enables resume in the cycle after stall falls.
//   - stall has no effect in IDLE or DONE.
//  AES_CTRL_STALL_EN undefined: the stall port does not exist and the sequence always runs unbroken.
// TESTING
//  1. rst=1 for 2 cycles, then release -> ready=1, busy=0, done=0, col=0, round=0.
//  2. NR=10, one start pulse -> 4 ld_en cycles (col 0-3); then 40 rnd_en cycles.
//     round goes 1..10. key_en is high 10 times. last_rnd is high in cycles 41-44.
//     done is high only in cycle 45.
//  3. start pulses in cycles 3, 20 and 45 of a running operation -> ignored; exactly one done.
//  4. rst asserted in cycle 20 (round 4) -> IDLE next edge, no done; a fresh start runs the full 45-cycle sequence.
//  5. start held high continuously, NR=10 -> done in cycles 45 and 91; ld_en restarts in cycle 47.
//  6. AES_CTRL_STALL_EN, stall=1 in cycles 10-12 -> col and round frozen, rnd_en=0 while stalled.
//     done moves to cycle 48.

Source files
------------

// File: rtl/aes_col_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_col_round_ctrl
//  Description : Sequencer for a column-serial AES-128 encryption datapath.
//                Optional stall input enabled by macro AES_CTRL_STALL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_col_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef AES_CTRL_STALL_EN
    input  logic       stall,
`endif
    output logic       ready,
    output logic       busy,
    output logic       ld_en,
    output logic       rnd_en,
    output logic       key_en,
    output logic       last_rnd,
    output logic [1:0] col,
    output logic [3:0] round,
    output logic       done
);

    localparam logic [3:0] c_NR = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_col;
    logic [1:0] w_col_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic       r_ready;
    logic       r_busy;
    logic       r_ld_en;
    logic       r_rnd_en;
    logic       r_key_en;
    logic       r_last_rnd;
    logic       r_done;
    logic       w_hold;

    // A stall freezes the sequence only while the datapath is active.
`ifdef AES_CTRL_STALL_EN
    assign w_hold = stall & ((r_state == S_LOAD) || (r_state == S_ROUND));
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_round_nxt = r_round;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_col_nxt   = 2'd0;
                    w_round_nxt = 4'd0;
                end
            end
            S_LOAD: begin
                if (!w_hold) begin
                    if (r_col == 2'd3) begin
                        w_state_nxt = S_ROUND;
                        w_col_nxt   = 2'd0;
                        w_round_nxt = 4'd1;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
            end
            S_ROUND: begin
                if (!w_hold) begin
                    if (r_col == 2'd3) begin
                        w_col_nxt = 2'd0;
                        if (r_round == c_NR) begin
                            w_state_nxt = S_DONE;
                            w_round_nxt = 4'd0;
                        end else begin
                            w_round_nxt = r_round + 4'd1;
                        end
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_col_nxt   = 2'd0;
                w_round_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_col_nxt   = 2'd0;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= 2'd0;
            r_round    <= 4'd0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_ld_en    <= 1'b0;
            r_rnd_en   <= 1'b0;
            r_key_en   <= 1'b0;
            r_last_rnd <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_round    <= w_round_nxt;
            r_ready    <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_ld_en    <= (w_state_nxt == S_LOAD);
            r_rnd_en   <= (w_state_nxt == S_ROUND);
            r_key_en   <= (w_state_nxt == S_ROUND) && (w_col_nxt == 2'd0);
            r_last_rnd <= (w_state_nxt == S_ROUND) && (w_round_nxt == c_NR);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign ld_en    = r_ld_en  & ~w_hold;
    assign rnd_en   = r_rnd_en & ~w_hold;
    assign key_en   = r_key_en & ~w_hold;
    assign last_rnd = r_last_rnd;
    assign col      = r_col;
    assign round    = r_round;
    assign done     = r_done;

endmodule
`default_nettype wire
